// File: rtl/ew_car_detect.sv
`default_nettype none
// ============================================================================
// Module   : ew_car_detect
// Brief    : Debounced east-west car request generator with service tracking,
//            saturating wait measurement and sticky illegal-light alarm.
// Revision : 1.0 - initial release
// ============================================================================
module ew_car_detect #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 3,
    parameter int WAIT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sensor_raw,
    input  logic [5:0]        lights,
    output logic              carew,
    output logic [WAIT_W-1:0] wait_cnt,
    output logic              starve,
    output logic              lights_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_QUAL   = 2'd1,
        ST_REQ    = 2'd2,
        ST_SERVED = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]  C_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  C_DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [WAIT_W-1:0] C_WAIT_ONE = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] C_WAIT_MAX = {WAIT_W{1'b1}};

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic                carew_q, carew_d;
    logic                starve_q, starve_d;
    logic                err_q, err_d;

    logic                w_sensor_s;
    logic                w_ew_green;
    logic                w_lights_ok;

    // Case-based decode so X/Z light values fall into the illegal branch.
    function automatic logic onehot3(input logic [2:0] g);
        case (g)
            3'b100, 3'b010, 3'b001: onehot3 = 1'b1;
            default:                onehot3 = 1'b0;
        endcase
    endfunction

    assign w_sensor_s = sync2_q;

    always_comb begin
        w_ew_green = 1'b0;
        case (lights[2:0])
            3'b100:  w_ew_green = 1'b1;
            default: w_ew_green = 1'b0;
        endcase
    end

    // Each group one-hot, and at least one direction showing red.
    assign w_lights_ok = onehot3(lights[5:3]) & onehot3(lights[2:0])
                       & (lights[3] | lights[0]);

    always_comb begin
        sync1_d = sensor_raw;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!w_ew_green && w_sensor_s) begin
                    if (DEB_CYCLES == 1) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_QUAL;
                        cnt_d   = C_CNT_ONE;
                    end
                end
            end
            ST_QUAL: begin
                if (!w_sensor_s || w_ew_green) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == C_DEB_LAST) begin
                    state_d = ST_REQ;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + C_CNT_ONE;
                end
            end
            ST_REQ: begin
                if (w_ew_green) begin
                    state_d = ST_SERVED;
                end
            end
            ST_SERVED: begin
                if (!w_ew_green) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Every edge taken while in REQ (including the exit edge) counts.
        if ((state_q != ST_REQ) && (state_d == ST_REQ)) begin
            wait_d = '0;
        end else if ((state_q == ST_REQ) && (wait_q != C_WAIT_MAX)) begin
            wait_d = wait_q + C_WAIT_ONE;
        end

        carew_d  = (state_d == ST_REQ);
        starve_d = (state_d == ST_REQ) && (wait_d == C_WAIT_MAX);
        err_d    = err_q | ~w_lights_ok;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            wait_q   <= '0;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            carew_q  <= 1'b0;
            starve_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wait_q   <= wait_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            carew_q  <= carew_d;
            starve_q <= starve_d;
            err_q    <= err_d;
        end
    end

    assign carew      = carew_q;
    assign wait_cnt   = wait_q;
    assign starve     = starve_q;
    assign lights_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ew_car_detect.sv
`default_nettype none
// ============================================================================
// Module   : tb_ew_car_detect
// Brief    : Directed self-checking bench for ew_car_detect (DEB=4, WAIT_W=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ew_car_detect;

    localparam logic [5:0] C_NS_GREEN = 6'b100_001;
    localparam logic [5:0] C_EW_GREEN = 6'b001_100;

    logic       clk;
    logic       rst;
    logic       sensor_raw;
    logic [5:0] lights;
    logic       carew;
    logic [3:0] wait_cnt;
    logic       starve;
    logic       lights_err;

    int n_cmp;
    int n_bad;

    ew_car_detect #(
        .DEB_CYCLES (4),
        .CNT_W      (3),
        .WAIT_W     (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sensor_raw (sensor_raw),
        .lights     (lights),
        .carew      (carew),
        .wait_cnt   (wait_cnt),
        .starve     (starve),
        .lights_err (lights_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        sensor_raw = 1'b0;
        lights     = C_NS_GREEN;
        rst        = 1'b1;
        #1;
        rst = 1'b0;
        #2;
        n_cmp++; if (carew !== 1'b0) begin n_bad++; $display("FAIL reset_carew: got %b want 0", carew); end
        n_cmp++; if (wait_cnt !== 4'd0) begin n_bad++; $display("FAIL reset_wait: got %0d want 0", wait_cnt); end
        n_cmp++; if (starve !== 1'b0) begin n_bad++; $display("FAIL reset_starve: got %b want 0", starve); end
        n_cmp++; if (lights_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", lights_err); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Raw sensor high from edge 0: request appears after edge 5, then latches.
    task automatic test_latency();
        sensor_raw = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            tick();
            n_cmp++;
            if (carew !== (i == 5)) begin
                n_bad++; $display("FAIL latency_edge%0d: carew=%b want %b", i, carew, (i == 5));
            end
        end
        sensor_raw = 1'b0;
        repeat (3) tick();
        n_cmp++; if (carew !== 1'b1) begin n_bad++; $display("FAIL latch_after_drop: carew=%b want 1", carew); end
        n_cmp++; if (wait_cnt !== 4'd3) begin n_bad++; $display("FAIL wait_after_3: got %0d want 3", wait_cnt); end
        n_cmp++; if (starve !== 1'b0) begin n_bad++; $display("FAIL starve_early: got %b want 0", starve); end
    endtask

    task automatic test_served();
        lights     = C_EW_GREEN;
        sensor_raw = 1'b1;
        tick();
        n_cmp++; if (carew !== 1'b0) begin n_bad++; $display("FAIL served_drop: carew=%b want 0", carew); end
        n_cmp++; if (wait_cnt !== 4'd4) begin n_bad++; $display("FAIL served_wait: got %0d want 4", wait_cnt); end
        for (int i = 1; i < 5; i++) begin
            tick();
            n_cmp++;
            if (carew !== 1'b0) begin n_bad++; $display("FAIL green_hold%0d: carew=%b want 0", i, carew); end
        end
        n_cmp++; if (wait_cnt !== 4'd4) begin n_bad++; $display("FAIL served_wait_hold: got %0d want 4", wait_cnt); end
        lights = C_NS_GREEN;
        for (int i = 0; i <= 4; i++) begin
            tick();
            n_cmp++;
            if (carew !== (i == 4)) begin
                n_bad++; $display("FAIL rerequest_edge%0d: carew=%b want %b", i, carew, (i == 4));
            end
        end
        n_cmp++; if (lights_err !== 1'b0) begin n_bad++; $display("FAIL legal_no_err: got %b want 0", lights_err); end
    endtask

    // Enters with a fresh request (wait_cnt=0); 4-bit counter saturates at 15.
    task automatic test_saturation();
        for (int i = 1; i <= 20; i++) begin
            tick();
            n_cmp++;
            if (wait_cnt !== ((i < 15) ? 4'(i) : 4'd15)) begin
                n_bad++; $display("FAIL sat_wait%0d: got %0d want %0d", i, wait_cnt, (i < 15) ? i : 15);
            end
            n_cmp++;
            if (starve !== (i >= 15)) begin
                n_bad++; $display("FAIL sat_starve%0d: got %b want %b", i, starve, (i >= 15));
            end
        end
        lights = C_EW_GREEN;
        tick();
        n_cmp++; if (carew !== 1'b0) begin n_bad++; $display("FAIL sat_served: carew=%b want 0", carew); end
        n_cmp++; if (starve !== 1'b0) begin n_bad++; $display("FAIL sat_starve_clr: got %b want 0", starve); end
        n_cmp++; if (wait_cnt !== 4'd15) begin n_bad++; $display("FAIL sat_wait_hold: got %0d want 15", wait_cnt); end
        lights = C_NS_GREEN;
        tick();
        n_cmp++; if (wait_cnt !== 4'd15) begin n_bad++; $display("FAIL idle_wait_hold: got %0d want 15", wait_cnt); end
    endtask

    task automatic test_debounce_pulses();
        do_reset();
        lights = C_NS_GREEN;
        for (int rep = 0; rep < 2; rep++) begin
            sensor_raw = 1'b1;
            for (int i = 0; i < 3; i++) begin
                tick();
                n_cmp++;
                if (carew !== 1'b0) begin n_bad++; $display("FAIL pulse%0d_hi%0d: carew=%b want 0", rep, i, carew); end
            end
            sensor_raw = 1'b0;
            for (int i = 0; i < 4; i++) begin
                tick();
                n_cmp++;
                if (carew !== 1'b0) begin n_bad++; $display("FAIL pulse%0d_lo%0d: carew=%b want 0", rep, i, carew); end
            end
        end
        sensor_raw = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            tick();
            n_cmp++;
            if (carew !== (i == 5)) begin
                n_bad++; $display("FAIL post_pulse_edge%0d: carew=%b want %b", i, carew, (i == 5));
            end
        end
    endtask

    task automatic test_lights_err();
        logic [5:0] bad [3];
        logic [5:0] good [3];
        bad[0]  = 6'b100_100;
        bad[1]  = 6'b110_001;
        bad[2]  = 6'b000_001;
        good[0] = 6'b010_001;
        good[1] = 6'b001_100;
        good[2] = 6'b001_010;
        do_reset();
        sensor_raw = 1'b0;
        for (int k = 0; k < 3; k++) begin
            lights = good[k];
            tick();
        end
        n_cmp++; if (lights_err !== 1'b0) begin n_bad++; $display("FAIL err_legal_seq: got %b want 0", lights_err); end
        for (int k = 0; k < 3; k++) begin
            do_reset();
            lights = bad[k];
            tick();
            lights = C_NS_GREEN;
            n_cmp++;
            if (lights_err !== 1'b1) begin n_bad++; $display("FAIL err_set%0d: got %b want 1", k, lights_err); end
            repeat (3) tick();
            n_cmp++;
            if (lights_err !== 1'b1) begin n_bad++; $display("FAIL err_sticky%0d: got %b want 1", k, lights_err); end
            rst = 1'b0;
            #1;
            n_cmp++;
            if (lights_err !== 1'b0) begin n_bad++; $display("FAIL err_clear%0d: got %b want 0", k, lights_err); end
            @(negedge clk);
            rst = 1'b1;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        lights = 6'b000_001;
        tick();
        lights     = C_NS_GREEN;
        sensor_raw = 1'b1;
        repeat (25) tick();
        n_cmp++; if (carew !== 1'b1) begin n_bad++; $display("FAIL pre_rst_carew: got %b want 1", carew); end
        n_cmp++; if (starve !== 1'b1) begin n_bad++; $display("FAIL pre_rst_starve: got %b want 1", starve); end
        n_cmp++; if (lights_err !== 1'b1) begin n_bad++; $display("FAIL pre_rst_err: got %b want 1", lights_err); end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (carew !== 1'b0) begin n_bad++; $display("FAIL async_carew: got %b want 0", carew); end
        n_cmp++; if (wait_cnt !== 4'd0) begin n_bad++; $display("FAIL async_wait: got %0d want 0", wait_cnt); end
        n_cmp++; if (starve !== 1'b0) begin n_bad++; $display("FAIL async_starve: got %b want 0", starve); end
        n_cmp++; if (lights_err !== 1'b0) begin n_bad++; $display("FAIL async_err: got %b want 0", lights_err); end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            tick();
            n_cmp++;
            if (carew !== (i == 5)) begin
                n_bad++; $display("FAIL requal_edge%0d: carew=%b want %b", i, carew, (i == 5));
            end
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst        = 1'b1;
        sensor_raw = 1'b0;
        lights     = C_NS_GREEN;
        test_reset();
        test_latency();
        test_served();
        test_saturation();
        test_debounce_pulses();
        test_lights_err();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
